// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in / serial-out transmitter.
package piso_pkg;

    localparam int PISO_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/piso_shifter_bit_counter.sv
// Up-counter with synchronous clear and terminal-count flag at MAX.
module bit_counter #(
    parameter int CW  = 3,
    parameter int MAX = 7
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CLR,
    input  logic          EN,
    output logic [CW-1:0] COUNT,
    output logic          TC
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = '0;
        end else if (EN) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;
    assign TC    = (count_q == MAX_C);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter: loads a word on valid/ready and streams it
// LSB-first, one bit per enabled clock, with a one-cycle DONE afterwards.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int  WIDTH = PISO_WIDTH_DEFAULT,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic             SHIFT_EN,
    output logic             SOUT,
    output logic             SOUT_VALID,
    output logic             SOUT_LAST,
    output logic             DONE
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             done_q,  done_d;

    logic [CW-1:0]    bit_count;
    logic             bit_tc;
    logic             cnt_clr;
    logic             cnt_en;

    // Counter is held at zero throughout IDLE so every word starts from bit 0.
    assign cnt_clr = (state_q == IDLE) || (SHIFT_EN && bit_tc);
    assign cnt_en  = (state_q == SHIFT) && SHIFT_EN;

    bit_counter #(
        .CW  (CW),
        .MAX (WIDTH - 1)
    ) u_bit_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (cnt_clr),
        .EN    (cnt_en),
        .COUNT (bit_count),
        .TC    (bit_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD_VALID) begin
                    shreg_d = DIN;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (SHIFT_EN) begin
                    if (bit_tc) begin
                        shreg_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    // Outputs depend on registered state only; DIN/LOAD_VALID never reach them.
    assign LOAD_READY = (state_q == IDLE);
    assign SOUT_VALID = (state_q == SHIFT);
    assign SOUT       = (state_q == SHIFT) && shreg_q[0];
    assign SOUT_LAST  = (state_q == SHIFT) && (bit_count == LAST_IDX);
    assign DONE       = done_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter at WIDTH=8 and WIDTH=2.
module tb_piso_shifter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] din;
    logic       load_valid;
    logic       shift_en;
    logic       load_ready, sout, sout_valid, sout_last, done;

    logic [1:0] din2;
    logic       load_valid2;
    logic       shift_en2;
    logic       load_ready2, sout2, sout_valid2, sout_last2, done2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(8)) dut8 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .DIN        (din),
        .LOAD_VALID (load_valid),
        .LOAD_READY (load_ready),
        .SHIFT_EN   (shift_en),
        .SOUT       (sout),
        .SOUT_VALID (sout_valid),
        .SOUT_LAST  (sout_last),
        .DONE       (done)
    );

    piso_shifter #(.WIDTH(2)) dut2 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .DIN        (din2),
        .LOAD_VALID (load_valid2),
        .LOAD_READY (load_ready2),
        .SHIFT_EN   (shift_en2),
        .SOUT       (sout2),
        .SOUT_VALID (sout_valid2),
        .SOUT_LAST  (sout_last2),
        .DONE       (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a word, then walk ncyc SHIFT cycles checking the per-cycle SOUT
    // and SOUT_LAST patterns; en_pat gives SHIFT_EN for the edge after each
    // cycle, and a stray load of 8'h00 is attempted during cycle inject_at.
    task automatic xfer8(input string tag, input logic [7:0] word,
                         input logic [15:0] exp_sout, input logic [15:0] exp_last,
                         input logic [15:0] en_pat, input int ncyc, input int inject_at);
        din        = word;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (c == inject_at) begin
                din        = 8'h00;
                load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            shift_en = en_pat[c];
            chk($sformatf("%s sout c%0d", tag, c), 32'(sout), 32'(exp_sout[c]));
            chk($sformatf("%s last c%0d", tag, c), 32'(sout_last), 32'(exp_last[c]));
            chk($sformatf("%s valid c%0d", tag, c), 32'(sout_valid), 32'd1);
            chk($sformatf("%s ready c%0d", tag, c), 32'(load_ready), 32'd0);
            chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'd0);
            tick();
        end
        load_valid = 1'b0;
        shift_en   = 1'b1;
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " ready with done"}, 32'(load_ready), 32'd1);
        chk({tag, " valid after"}, 32'(sout_valid), 32'd0);
        tick();
        chk({tag, " done drops"}, 32'(done), 32'd0);
        chk({tag, " stays idle"}, 32'(sout_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        din         = 8'h00;
        load_valid  = 1'b0;
        shift_en    = 1'b0;
        din2        = 2'b00;
        load_valid2 = 1'b0;
        shift_en2   = 1'b0;

        #2;
        chk("rst ready", 32'(load_ready), 32'd1);
        chk("rst sout", 32'(sout), 32'd0);
        chk("rst valid", 32'(sout_valid), 32'd0);
        chk("rst last", 32'(sout_last), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // SHIFT_EN ignored in IDLE
        shift_en = 1'b1;
        tick();
        chk("idle shift_en ready", 32'(load_ready), 32'd1);
        chk("idle shift_en sout", 32'(sout_valid), 32'd0);

        // A5 -> 1,0,1,0,0,1,0,1
        xfer8("basic", 8'hA5, 16'b0000_0000_1010_0101, 16'h0080, 16'hFFFF, 8, -1);

        // 3C with 3-cycle stall after bit2: 0,0,1,1,1,1,1,1,1,0,0
        xfer8("stall", 8'h3C, 16'b0000_0001_1111_1100, 16'h0400, 16'hFFE3, 11, -1);

        // FF with a load attempt of 00 during bit 3
        xfer8("ldshift", 8'hFF, 16'h00FF, 16'h0080, 16'hFFFF, 8, 3);

        // Reset mid-transfer at bit 4
        din        = 8'hFF;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre-rst sout bit4", 32'(sout), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst sout", 32'(sout), 32'd0);
        chk("async rst valid", 32'(sout_valid), 32'd0);
        chk("async rst last", 32'(sout_last), 32'd0);
        chk("async rst ready", 32'(load_ready), 32'd1);
        chk("async rst done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("post-rst no done c%0d", c), 32'(done), 32'd0);
            chk($sformatf("post-rst idle c%0d", c), 32'(sout_valid), 32'd0);
            tick();
        end
        xfer8("after-rst", 8'h81, 16'b0000_0000_1000_0001, 16'h0080, 16'hFFFF, 8, -1);

        // Back-to-back with LOAD_VALID held high: 0F then F0
        din        = 8'h0F;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        din = 8'hF0;
        begin
            logic [7:0] seq_a;
            logic [7:0] seq_b;
            seq_a = 8'b0000_1111;
            seq_b = 8'b1111_0000;
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("b2b A sout c%0d", c), 32'(sout), 32'(seq_a[c]));
                chk($sformatf("b2b A last c%0d", c), 32'(sout_last), 32'(c == 7));
                tick();
            end
            chk("b2b A done", 32'(done), 32'd1);
            chk("b2b A ready", 32'(load_ready), 32'd1);
            chk("b2b gap valid", 32'(sout_valid), 32'd0);
            tick();
            load_valid = 1'b0;
            chk("b2b B accepted", 32'(sout_valid), 32'd1);
            chk("b2b B done low", 32'(done), 32'd0);
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("b2b B sout c%0d", c), 32'(sout), 32'(seq_b[c]));
                chk($sformatf("b2b B last c%0d", c), 32'(sout_last), 32'(c == 7));
                tick();
            end
            chk("b2b B done", 32'(done), 32'd1);
            tick();
            chk("b2b B done drops", 32'(done), 32'd0);
        end

        // WIDTH=2, DIN=2'b10 -> 0,1
        din2        = 2'b10;
        load_valid2 = 1'b1;
        shift_en2   = 1'b1;
        tick();
        load_valid2 = 1'b0;
        chk("w2 bit0", 32'(sout2), 32'd0);
        chk("w2 last0", 32'(sout_last2), 32'd0);
        chk("w2 valid0", 32'(sout_valid2), 32'd1);
        tick();
        chk("w2 bit1", 32'(sout2), 32'd1);
        chk("w2 last1", 32'(sout_last2), 32'd1);
        chk("w2 done early", 32'(done2), 32'd0);
        tick();
        chk("w2 done", 32'(done2), 32'd1);
        chk("w2 ready", 32'(load_ready2), 32'd1);
        chk("w2 valid after", 32'(sout_valid2), 32'd0);
        tick();
        chk("w2 done drops", 32'(done2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
